// File: rtl/rr_grant_seq8.sv
// Eight-way round-robin grant sequencer driving the {a,b,c} select of a 3-to-8 decoder.
// A grant is held until done, the owner's request drops, or the hold limit is reached.
module rr_grant_seq8 #(
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic       gnt_a,
  output logic       gnt_b,
  output logic       gnt_c,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);
  localparam logic       HOLD_EN  = (HOLD_MAX != 0);

  state_t     state_reg, state_next;
  logic [2:0] idx_reg, idx_next;
  logic [2:0] ptr_reg, ptr_next;
  logic [7:0] hcnt_reg, hcnt_next;
  logic       timeout_reg, timeout_next;

  logic [7:0] rot;
  logic [2:0] off;
  logic [2:0] pick;
  logic       hold_hit;
  logic       release_now;

  // Rotate requests so bit 0 is the requester currently holding top priority.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_rot
      assign rot[gi] = req[3'(ptr_reg + 3'(gi))];
    end
  endgenerate

  always_comb begin
    off = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (rot[k]) off = 3'(k);
    end
  end

  assign pick        = ptr_reg + off;
  assign hold_hit    = HOLD_EN && (hcnt_reg == HOLD_LIM);
  assign release_now = done || !req[idx_reg] || hold_hit;

  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    ptr_next     = ptr_reg;
    hcnt_next    = hcnt_reg;
    timeout_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (|req) begin
          idx_next   = pick;
          hcnt_next  = 8'd1;
          state_next = GRANT;
        end
      end
      GRANT: begin
        if (release_now) begin
          ptr_next     = idx_reg + 3'd1;
          state_next   = IDLE;
          // Only the hold limit can release with done low and the request still up.
          timeout_next = !done && req[idx_reg];
        end else begin
          hcnt_next = hcnt_reg + 8'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      idx_reg     <= 3'd0;
      ptr_reg     <= 3'd0;
      hcnt_reg    <= 8'd0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      ptr_reg     <= ptr_next;
      hcnt_reg    <= hcnt_next;
      timeout_reg <= timeout_next;
    end
  end

  // idx is left in place after release; consumers qualify it with gnt_valid.
  assign {gnt_a, gnt_b, gnt_c} = idx_reg;
  assign gnt_valid             = (state_reg == GRANT);
  assign timeout               = timeout_reg;

endmodule

// File: tb/tb_rr_grant_seq8.sv
// Directed table-driven bench for rr_grant_seq8 with HOLD_MAX=4, plus a timeout-driven rotation sequence.
module tb_rr_grant_seq8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic       done = 1'b0;
  logic       gnt_a, gnt_b, gnt_c, gnt_valid, timeout;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic       ev;
    logic [2:0] eidx;
    logic       eto;
    string      name;
  } vec_t;

  vec_t tbl[$];

  rr_grant_seq8 #(.HOLD_MAX(4)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .gnt_c(gnt_c),
    .gnt_valid(gnt_valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic add(input logic r, input logic [7:0] q, input logic d,
                     input logic ev, input logic [2:0] ei, input logic et, input string nm);
    vec_t v;
    v.rst = r; v.req = q; v.done = d; v.ev = ev; v.eidx = ei; v.eto = et; v.name = nm;
    tbl.push_back(v);
  endtask

  // Inputs are driven mid-cycle; outputs are compared 1 time unit after the next rising edge.
  task automatic step(input logic r, input logic [7:0] q, input logic d,
                      input logic ev, input logic [2:0] ei, input logic et,
                      input string nm, input int n);
    logic [4:0] got, exp;
    @(negedge clk);
    rst = r; req = q; done = d;
    @(posedge clk);
    #1;
    got = {gnt_valid, gnt_a, gnt_b, gnt_c, timeout};
    exp = {ev, ei, et};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d] rst=%0b req=%02h done=%0b got valid=%0b idx=%0d timeout=%0b want valid=%0b idx=%0d timeout=%0b",
               nm, n, r, q, d, got[4], got[3:1], got[0], ev, ei, et);
    end else begin
      $display("ok   %s[%0d] req=%02h done=%0b valid=%0b idx=%0d timeout=%0b",
               nm, n, q, d, got[4], got[3:1], got[0]);
    end
  endtask

  initial begin
    // reset / idle
    add(1, 8'h00, 0, 0, 3'd0, 0, "reset");
    add(1, 8'h00, 0, 0, 3'd0, 0, "reset");
    add(0, 8'h00, 0, 0, 3'd0, 0, "idle");
    // single requester 5, done in third grant cycle
    add(0, 8'h20, 0, 1, 3'd5, 0, "single");
    add(0, 8'h20, 0, 1, 3'd5, 0, "single");
    add(0, 8'h20, 0, 1, 3'd5, 0, "single");
    add(0, 8'h20, 1, 0, 3'd5, 0, "single");
    // ptr now 6: 6 beats 0
    add(0, 8'h41, 0, 1, 3'd6, 0, "ptr6");
    add(0, 8'h41, 1, 0, 3'd6, 0, "ptr6");
    // ptr now 7: 7 beats 0, releasing 7 wraps ptr to 0
    add(0, 8'h81, 0, 1, 3'd7, 0, "ptr7");
    add(0, 8'h81, 1, 0, 3'd7, 0, "ptr7");
    // full rotation with done held high (ignored while idle)
    for (int k = 0; k < 9; k++) begin
      add(0, 8'hFF, 1, 1, 3'(k % 8), 0, "rotate");
      add(0, 8'hFF, 1, 0, 3'(k % 8), 0, "rotate");
    end
    // ptr now 1: request drop releases owner 7, ptr wraps to 0
    add(0, 8'h81, 0, 1, 3'd7, 0, "drop");
    add(0, 8'h01, 0, 0, 3'd7, 0, "drop");
    add(0, 8'h81, 0, 1, 3'd0, 0, "wrap");
    add(0, 8'h81, 1, 0, 3'd0, 0, "wrap");
    // timeout: 4 valid cycles, pulse in the idle cycle, regrant after
    for (int k = 0; k < 4; k++) add(0, 8'h08, 0, 1, 3'd3, 0, "hold");
    add(0, 8'h08, 0, 0, 3'd3, 1, "timeout");
    add(0, 8'h08, 0, 1, 3'd3, 0, "regrant");
    for (int k = 0; k < 3; k++) add(0, 8'h08, 0, 1, 3'd3, 0, "hold2");
    // done coinciding with the hold limit is a normal release
    add(0, 8'h08, 1, 0, 3'd3, 0, "done_at_lim");
    // reset mid-grant; 0x24 regrant proves ptr was cleared (stale ptr 4 would pick 5)
    add(0, 8'h04, 0, 1, 3'd2, 0, "pre_rst");
    add(1, 8'h04, 1, 0, 3'd0, 0, "mid_rst");
    add(0, 8'h24, 0, 1, 3'd2, 0, "post_rst");

    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i].rst, tbl[i].req, tbl[i].done, tbl[i].ev, tbl[i].eidx, tbl[i].eto, tbl[i].name, i);

    // Fairness via the hold limit: all requests high, no done, owners 0..7,0 each held 4 cycles.
    step(1, 8'hFF, 0, 0, 3'd0, 0, "fair_rst", 0);
    for (int g = 0; g < 9; g++) begin
      for (int c = 0; c < 4; c++)
        step(0, 8'hFF, 0, 1, 3'(g % 8), 0, "fair_hold", g);
      step(0, 8'hFF, 0, 0, 3'(g % 8), 1, "fair_to", g);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
